// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the five-stage pipeline.
// Resolves data-memory freezes, EX-stage redirects and load-use hazards
// (priority in that order) into PC / IF-ID / ID-EX controls, inserts
// LU_BUBBLES bubbles per load-use hazard and keeps saturating event counters.
module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,   // legal range 1..3
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_branch,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic {S_RUN, S_LU} state_t;

  localparam logic [1:0] LU_EXTRA = 2'(LU_BUBBLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  logic br;
  logic lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Hazard qualifiers: a redirect needs a real EX instruction; a load-use
  // hazard needs a real load writing a non-x0 register that ID really reads.
  always_comb begin
    br = is_branch & ex_valid;
    lu = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
         ((id_rs1_en & (id_rs1 == ex_rd)) | (id_rs2_en & (id_rs2 == ex_rd)));
  end

  // Control outputs (zero latency) and next state / counter values.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    freeze_cnt_d = freeze_cnt_q;

    if (!rst_n) begin
      // Controls stay quiet while reset is held; the flops clear on the edge.
    end else if (mem_busy) begin
      // Back end is held: state and bubble count wait for memory.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      pipe_freeze  = 1'b1;
      freeze_cnt_d = sat_inc(freeze_cnt_q);
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (br) begin
            // ID holds the wrong path, so its load-use match is meaningless.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
          end else if (lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            if (LU_BUBBLES > 1) begin
              state_d = S_LU;
              bcnt_d  = LU_EXTRA;
            end
          end
        end
        S_LU: begin
          // EX holds a bubble here, so br and lu cannot be meaningful.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          bcnt_d      = bcnt_q - 2'd1;
          if (bcnt_q <= 2'd1) begin
            state_d = S_RUN;
            bcnt_d  = 2'd0;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (!rst_n) begin
      state_q      <= S_RUN;
      bcnt_q       <= 2'd0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign flush_cnt  = flush_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share one stimulus
// stream: A (1 bubble, 16-bit counters) and B (3 bubbles, 4-bit counters).
// Each is compared every cycle against a bubbles-remaining reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       is_branch, ex_valid, ex_is_load, id_valid;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_rs1_en, id_rs2_en, mem_busy;

  logic        pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_flush_a, pipe_freeze_a;
  logic [15:0] flush_cnt_a, stall_cnt_a, freeze_cnt_a;
  logic        pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_flush_b, pipe_freeze_b;
  logic [3:0]  flush_cnt_b, stall_cnt_b, freeze_cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int nbub[2]   = '{1, 3};
  int cmax[2]   = '{65535, 15};
  int rem[2]    = '{0, 0};
  int fcnt[2]   = '{0, 0};
  int scnt[2]   = '{0, 0};
  int zcnt[2]   = '{0, 0};
  bit known     = 1'b0;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_FREEZE = 5'b11001;
  localparam logic [4:0] C_BUBBLE = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .is_branch(is_branch), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .mem_busy(mem_busy), .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .pipe_freeze(pipe_freeze_a),
    .flush_cnt(flush_cnt_a), .stall_cnt(stall_cnt_a), .freeze_cnt(freeze_cnt_a)
  );

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .is_branch(is_branch), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .mem_busy(mem_busy), .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .pipe_freeze(pipe_freeze_b),
    .flush_cnt(flush_cnt_b), .stall_cnt(stall_cnt_b), .freeze_cnt(freeze_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_br();
    return is_branch && ex_valid;
  endfunction

  function automatic bit ref_lu();
    return ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
           ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
  endfunction

  function automatic logic [4:0] ref_ctrl(input int i);
    if (!rst_n)      return C_NONE;
    if (mem_busy)    return C_FREEZE;
    if (rem[i] > 0)  return C_BUBBLE;
    if (ref_br())    return C_FLUSH;
    if (ref_lu())    return C_BUBBLE;
    return C_NONE;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_edge();
    bit b = ref_br();
    bit l = ref_lu();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rem[i] = 0; fcnt[i] = 0; scnt[i] = 0; zcnt[i] = 0;
      end else if (mem_busy) begin
        zcnt[i] = sat(zcnt[i], cmax[i]);
      end else if (rem[i] > 0) begin
        rem[i]--;
      end else if (b) begin
        fcnt[i] = sat(fcnt[i], cmax[i]);
      end else if (l) begin
        scnt[i] = sat(scnt[i], cmax[i]);
        rem[i]  = nbub[i] - 1;
      end
    end
    if (!rst_n) known = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven: check both
  // instances mid-cycle, then cross the rising edge and step the model.
  task automatic tick(input string tag);
    #1;
    chk({tag, "/ctrl_a"}, {27'd0, pc_stall_a, if_id_stall_a, if_id_flush_a,
                           id_ex_flush_a, pipe_freeze_a}, {27'd0, ref_ctrl(0)});
    chk({tag, "/ctrl_b"}, {27'd0, pc_stall_b, if_id_stall_b, if_id_flush_b,
                           id_ex_flush_b, pipe_freeze_b}, {27'd0, ref_ctrl(1)});
    if (known) begin
      chk({tag, "/flush_a"},  32'(flush_cnt_a),  32'(fcnt[0]));
      chk({tag, "/stall_a"},  32'(stall_cnt_a),  32'(scnt[0]));
      chk({tag, "/freeze_a"}, 32'(freeze_cnt_a), 32'(zcnt[0]));
      chk({tag, "/flush_b"},  32'(flush_cnt_b),  32'(fcnt[1]));
      chk({tag, "/stall_b"},  32'(stall_cnt_b),  32'(scnt[1]));
      chk({tag, "/freeze_b"}, 32'(freeze_cnt_b), 32'(zcnt[1]));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_in();
    is_branch = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0; mem_busy = 0;
  endtask

  // EX: lw x5 ; ID: add x6, x5, x7
  task automatic set_lu();
    clear_in();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd7; id_rs1_en = 1; id_rs2_en = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    @(negedge clk);

    // Reset held two cycles with a load-use hazard present.
    set_lu();
    tick("rst0");
    tick("rst1");
    rst_n = 1;
    clear_in();
    tick("post_rst");

    // Load-use: A bubbles once, B three times.
    set_lu();
    tick("lu");
    clear_in();
    tick("lu_next");
    chk("lu1_stall_cnt", 32'(stall_cnt_a), 32'd1);
    chk("lu1_idle_a", {31'd0, pc_stall_a | if_id_stall_a | id_ex_flush_a}, 32'd0);
    tick("lu_tail0");
    tick("lu_tail1");

    // x0 destination, then matching rs2 that is not read.
    set_lu(); ex_rd = 5'd0; id_rs1 = 5'd0;
    tick("x0");
    set_lu(); id_rs1 = 5'd1; id_rs2 = 5'd5; id_rs2_en = 0;
    tick("rs2_unused");

    // Branch and load-use together: flush wins.
    rst_n = 0; clear_in();
    tick("rst_br");
    rst_n = 1;
    set_lu(); is_branch = 1;
    tick("br_lu");
    clear_in();
    tick("br_lu_next");
    chk("br_lu_flush_cnt", 32'(flush_cnt_a), 32'd1);
    chk("br_lu_stall_cnt", 32'(stall_cnt_a), 32'd0);

    // Three bubbles on B with mem_busy in the second bubble cycle.
    rst_n = 0;
    tick("rst_lu3");
    rst_n = 1;
    set_lu();
    tick("lu3_b1");
    clear_in(); mem_busy = 1;
    tick("lu3_freeze");
    mem_busy = 0;
    tick("lu3_b2");
    tick("lu3_b3");
    tick("lu3_done");
    chk("lu3_stall_cnt", 32'(stall_cnt_b), 32'd1);
    chk("lu3_freeze_cnt", 32'(freeze_cnt_b), 32'd1);

    // Reset in the middle of B's bubble run abandons the rest.
    set_lu();
    tick("mid_lu");
    clear_in(); rst_n = 0;
    tick("mid_rst");
    rst_n = 1;
    tick("mid_after");

    // Saturation: 2^4 + 5 consecutive flushes on the 4-bit counter.
    clear_in(); is_branch = 1; ex_valid = 1;
    repeat (21) tick("sat");
    clear_in();
    tick("sat_end");
    chk("sat_flush_b", 32'(flush_cnt_b), 32'd15);

    // Randomised traffic with small register indices to provoke matches.
    for (int n = 0; n < 600; n++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      is_branch  = ($urandom_range(0, 5) == 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_is_load = 1'($urandom);
      ex_rd      = 5'($urandom_range(0, 3));
      id_valid   = ($urandom_range(0, 4) != 0);
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_rs1_en  = 1'($urandom);
      id_rs2_en  = 1'($urandom);
      mem_busy   = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage CPU. It takes the EX-stage redirect flag from the branch/flush detector, a load-use comparison between EX and ID, and the data-memory busy flag. From these it drives the stall and flush enables of the PC, IF/ID and ID/EX registers and a freeze for the back end. It sequences multi-cycle load-use bubbles with a small FSM and keeps saturating event counters for performance debug.

## Interface
- LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3
- CNT_W, 16, width of the event counters
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- is_branch  in  1  EX instruction redirects (npc != pc+4)
- ex_valid  in  1  EX stage holds a real instruction (not a bubble)
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_rs1_en, id_rs2_en  in  1 each  ID actually reads rs1 / rs2
- mem_busy  in  1  data memory not ready this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID to bubble
- id_ex_flush  out  1  clear ID/EX to bubble
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- flush_cnt  out  CNT_W  branch flushes taken, saturating
- stall_cnt  out  CNT_W  load-use hazards detected, saturating
- freeze_cnt  out  CNT_W  cycles frozen by mem_busy, saturating

## Operation
- Definitions:
  - br = is_branch & ex_valid.
  - lu = ex_valid & ex_is_load & (ex_rd != 0) & id_valid & ((id_rs1_en & id_rs1 == ex_rd) | (id_rs2_en & id_rs2 == ex_rd)).
- FSM states: S_RUN, S_LU. A bubble counter bcnt (2 bits) is used in S_LU.
- Priority in every state: mem_busy > br > lu.
- mem_busy = 1, any state:
  - pc_stall = if_id_stall = pipe_freeze = 1; both flushes 0.
  - State and bcnt hold; freeze_cnt increments.
- S_RUN, no mem_busy, br = 1:
  - if_id_flush = id_ex_flush = 1; pc_stall = 0, so the PC loads npc.
  - flush_cnt increments. The lu check is suppressed because ID holds the wrong path.
- S_RUN, no mem_busy, no br, lu = 1:
  - pc_stall = if_id_stall = id_ex_flush = 1 (one bubble); stall_cnt increments.
  - If LU_BUBBLES > 1: go to S_LU with bcnt = LU_BUBBLES-1. Otherwise stay in S_RUN.
- S_LU, no mem_busy:
  - pc_stall = if_id_stall = id_ex_flush = 1; bcnt decrements.
  - When bcnt reaches 1, return to S_RUN on that edge.
  - br and lu are ignored in S_LU, since EX holds a bubble.
- Otherwise all control outputs are 0.
- Counters saturate at all-ones and never wrap.
- while rst_n = 0:
  - All control outputs are forced to 0.
  - On the edge: state = S_RUN, bcnt = 0, all counters = 0.
  - Reset asserted mid-S_LU abandons the remaining bubbles.

## Timing
- Control outputs are combinational from current inputs and state, with zero latency, so they act on the same clock edge the hazard is seen.
- The state, bcnt and counter updates are registered and visible one cycle after the triggering cycle.
- After reset release, the first cycle is in S_RUN and all counters read 0.
- Simultaneous br and lu: flush only; stall_cnt unchanged.
- Simultaneous mem_busy and br: freeze only; br is re-evaluated once mem_busy drops, because EX is held. flush_cnt counts once, in the cycle the flush is actually issued.
- Simultaneous mem_busy and lu: freeze only; stall_cnt does not increment until the cycle the bubble is issued.
- With LU_BUBBLES = 3, one hazard produces exactly 3 consecutive bubble cycles. Interleaved mem_busy cycles extend the sequence without adding bubbles.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with lu conditions present.
  - Required: all control outputs 0; counters 0 after release.
- Load-use, LU_BUBBLES = 1: EX `lw x5`, ID `add x6,x5,x7`.
  - Required: one cycle with pc_stall = if_id_stall = id_ex_flush = 1; next cycle all 0; stall_cnt = 1.
- Branch over hazard: br = 1 and lu = 1 in the same cycle.
  - Required: if_id_flush = id_ex_flush = 1, pc_stall = 0; flush_cnt = 1, stall_cnt = 0.
- x0 and unused source: ex_rd = 0 with a matching rs1, then a matching rs2 with id_rs2_en = 0.
  - Required: no stall in either case.
- LU_BUBBLES = 3 with mem_busy = 1 in the 2nd bubble cycle.
  - Required: freeze in that cycle, bcnt held; 3 bubble cycles in total; freeze_cnt = 1.
- Saturation: preload conditions for 2^CNT_W + 5 branch flushes (CNT_W = 4 variant).
  - Required: flush_cnt holds at 15.
